bpf_scheduler: RTL and testbench
================================

BPF_SCHEDULER -- requirements
Module: bpf_scheduler

Interface
REQ-001 Parameter ACC_W, default 22: state/accumulator width; every output is slice [ACC_W-1:ACC_W-14].
REQ-002 clk50MHz  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_v  input  1  voltage-channel sample request (level).
REQ-005 in_v  input  13  voltage sample, signed.
REQ-006 ack_v  output  1  one-cycle pulse: voltage result written.
REQ-007 out_v, out_v_delay  output  14 each  voltage filter output, current and one-update-old, signed.
REQ-008 req_i, in_i, ack_i, out_i, out_i_delay  same widths and meaning as REQ-004..007, for the current channel.
REQ-009 flush  input  1  zero all channel state (level, sampled in IDLE).
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 One shared biquad engine; per-channel state y0, y1, x1, x2 (each ACC_W signed).
REQ-012 FSM IDLE -> LOAD -> CALC -> WRITE -> IDLE; each state lasts exactly one cycle.
REQ-013 In IDLE, flush high SHALL clear all 8 state registers, stay in IDLE and grant nothing that cycle.
REQ-014 In IDLE, flush low and at least one req high SHALL grant one channel and move to LOAD.
REQ-015 Arbitration: single request wins; if both requests are high, the channel not granted last wins (round-robin); pointer resets to "voltage last".
REQ-016 LOAD captures the granted channel's in_x and state into operand registers; in_x is sampled only here.
REQ-017 CALC: x = 9*in, sign-extended to ACC_W.
REQ-018 CALC: a = y0 + y0>>>1 + y0>>>2 + y0>>>5 + y0>>>8.
REQ-019 CALC: b = y1 - y1>>>4 - y1>>>7.
REQ-020 CALC: y_new = a - b + x - x2; all shifts arithmetic (floor).
REQ-021 WRITE updates state (y1<=y0, y0<=y_new, x2<=x1, x1<=x) and pulses that channel's ack for exactly one cycle.
REQ-022 out_x = y0 slice and out_x_delay = y1 slice, driven from registered state; they change only on the cycle after WRITE or on flush.
REQ-023 Latency: grant edge to ack pulse = 3 cycles; back-to-back service = 4 cycles per sample.
REQ-024 Requester holds req and in until ack; the block SHALL NOT regrant a channel whose req is still high in the cycle immediately after its ack.
REQ-025 A req dropped before grant is not serviced; a req dropped after LOAD does not abort the operation.
REQ-026 flush asserted outside IDLE is ignored until IDLE is reached, then takes priority over pending requests.
REQ-027 The ungranted channel's state and outputs SHALL be unchanged during the other channel's operation.

Reset
REQ-028 rst_n low SHALL force IDLE, all state and operand registers to 0, all outputs to 0, and the arbitration pointer to "voltage last", asynchronously.
REQ-029 Reset mid-operation aborts without ack; after release the first grant occurs no earlier than the second rising edge.

Configuration
REQ-030 Macro BPF_SCHED_SAT_EN defined: y_new computed at ACC_W+3 bits and saturated to ACC_W signed limits before writeback.
REQ-031 Macro BPF_SCHED_SAT_EN undefined: y_new wraps (two's complement truncation to ACC_W); no other behaviour differs.

Verification
REQ-032 Reset then req_v=1, in_v=100 -> ack_v 3 cycles after grant; out_v=(900>>8)=3, out_v_delay=0.
REQ-033 req_v and req_i both high from IDLE after reset -> current channel served first, voltage 4 cycles later; acks never overlap.
REQ-034 Impulse in_v=4095 once, then 0 for 2000 requests -> out_v matches golden model of REQ-017..021 bit-exact and decays toward 0.
REQ-035 flush pulsed while busy -> current op completes with ack; all outputs read 0 one cycle after the next IDLE.
REQ-036 rst_n low during CALC -> no ack; all outputs 0 immediately.
REQ-037 Constant in_v=-4096 with large y0 forced (BPF_SCHED_SAT_EN on/off) -> y0 clamps at -2^21 / wraps, respectively.

Source files
------------

// File: rtl/bpf_scheduler.sv
// bpf_scheduler: two-channel (voltage / current) biquad band-pass filter
// sharing one arithmetic engine behind a round-robin arbiter.
// Optional feature: define BPF_SCHED_SAT_EN to saturate y_new to the ACC_W
// signed range instead of wrapping.
`timescale 1ns/1ps

module bpf_scheduler #(
  parameter int ACC_W = 22
) (
  input  logic               clk50MHz,
  input  logic               rst_n,
  input  logic               req_v,
  input  logic signed [12:0] in_v,
  output logic               ack_v,
  output logic signed [13:0] out_v,
  output logic signed [13:0] out_v_delay,
  input  logic               req_i,
  input  logic signed [12:0] in_i,
  output logic               ack_i,
  output logic signed [13:0] out_i,
  output logic signed [13:0] out_i_delay,
  input  logic               flush,
  output logic               busy
);

`ifdef BPF_SCHED_SAT_EN
  localparam int W = ACC_W + 3;
`else
  localparam int W = ACC_W;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, CALC, WRITE} state_t;

  state_t state, state_nx;
  logic   armed;      // set one edge after reset release; gates the first grant
  logic   last_i;     // round-robin pointer: 1 = current channel granted last
  logic   sel_i;      // channel owning the engine: 1 = current
  logic   grant, grant_i;
  logic   elig_v, elig_i;

  // per-channel filter state
  logic signed [ACC_W-1:0] y0_v, y1_v, x1_v, x2_v;
  logic signed [ACC_W-1:0] y0_i, y1_i, x1_i, x2_i;

  // operand and result registers of the shared engine
  logic signed [12:0]      op_in;
  logic signed [ACC_W-1:0] op_y0, op_y1, op_x1, op_x2;
  logic signed [ACC_W-1:0] res_y, res_x;

  // datapath nets
  logic signed [ACC_W-1:0] x_ext, x9, y_new;
  logic signed [W-1:0]     y0w, y1w, xw, x2w, a_w, b_w, yw;

  // A channel whose ack is showing is not eligible, so a requester still
  // holding req in its ack cycle is not served twice.
  assign elig_v = req_v & ~ack_v;
  assign elig_i = req_i & ~ack_i;

  assign busy        = (state != IDLE);
  assign out_v       = y0_v[ACC_W-1 -: 14];
  assign out_v_delay = y1_v[ACC_W-1 -: 14];
  assign out_i       = y0_i[ACC_W-1 -: 14];
  assign out_i_delay = y1_i[ACC_W-1 -: 14];

  // next-state and grant decision
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_i  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && armed && (elig_v || elig_i)) begin
          grant    = 1'b1;
          grant_i  = elig_i && (!elig_v || !last_i);
          state_nx = LOAD;
        end
      end
      LOAD:    state_nx = CALC;
      CALC:    state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state, arbitration pointer and registered ack pulses
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      armed  <= 1'b0;
      last_i <= 1'b0;
      sel_i  <= 1'b0;
      ack_v  <= 1'b0;
      ack_i  <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      ack_v <= (state == WRITE) && !sel_i;
      ack_i <= (state == WRITE) && sel_i;
      if (grant) begin
        sel_i  <= grant_i;
        last_i <= grant_i;
      end
    end
  end

  // biquad arithmetic on the operand registers
  always_comb begin
    x_ext = ACC_W'(op_in);
    x9    = (x_ext <<< 3) + x_ext;
    y0w   = W'(op_y0);
    y1w   = W'(op_y1);
    xw    = W'(x9);
    x2w   = W'(op_x2);
    a_w   = y0w + (y0w >>> 1) + (y0w >>> 2) + (y0w >>> 5) + (y0w >>> 8);
    b_w   = y1w - (y1w >>> 4) - (y1w >>> 7);
    yw    = a_w - b_w + xw - x2w;
  end

`ifdef BPF_SCHED_SAT_EN
  localparam logic signed [W-1:0] SMAX = {{(W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {{(W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // clamp the widened result to the ACC_W signed range
  always_comb begin
    if (yw > SMAX)      y_new = SMAX[ACC_W-1:0];
    else if (yw < SMIN) y_new = SMIN[ACC_W-1:0];
    else                y_new = yw[ACC_W-1:0];
  end
`else
  // result wraps at ACC_W bits
  always_comb begin
    y_new = yw;
  end
`endif

  // operand capture in LOAD, result capture in CALC
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      op_in <= '0;
      op_y0 <= '0;
      op_y1 <= '0;
      op_x1 <= '0;
      op_x2 <= '0;
      res_y <= '0;
      res_x <= '0;
    end else begin
      case (state)
        LOAD: begin
          op_in <= sel_i ? in_i : in_v;
          op_y0 <= sel_i ? y0_i : y0_v;
          op_y1 <= sel_i ? y1_i : y1_v;
          op_x1 <= sel_i ? x1_i : x1_v;
          op_x2 <= sel_i ? x2_i : x2_v;
        end
        CALC: begin
          res_y <= y_new;
          res_x <= x9;
        end
        default: ;
      endcase
    end
  end

  // channel state: cleared by flush in IDLE, updated in WRITE
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      y0_v <= '0; y1_v <= '0; x1_v <= '0; x2_v <= '0;
      y0_i <= '0; y1_i <= '0; x1_i <= '0; x2_i <= '0;
    end else if (state == IDLE && flush) begin
      y0_v <= '0; y1_v <= '0; x1_v <= '0; x2_v <= '0;
      y0_i <= '0; y1_i <= '0; x1_i <= '0; x2_i <= '0;
    end else if (state == WRITE) begin
      if (sel_i) begin
        y1_i <= op_y0; y0_i <= res_y; x2_i <= op_x1; x1_i <= res_x;
      end else begin
        y1_v <= op_y0; y0_v <= res_y; x2_v <= op_x1; x1_v <= res_x;
      end
    end
  end

endmodule

// File: tb/tb_bpf_scheduler.sv
// Self-checking bench for bpf_scheduler: hand-derived vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
`timescale 1ns/1ps

module tb_bpf_scheduler;
  localparam int ACC_W = 22;

  logic               clk50MHz = 1'b0;
  logic               rst_n;
  logic               req_v, req_i, flush;
  logic signed [12:0] in_v, in_i;
  logic               ack_v, ack_i, busy;
  logic signed [13:0] out_v, out_v_delay, out_i, out_i_delay;

  bpf_scheduler #(.ACC_W(ACC_W)) dut (
    .clk50MHz(clk50MHz), .rst_n(rst_n),
    .req_v(req_v), .in_v(in_v), .ack_v(ack_v), .out_v(out_v), .out_v_delay(out_v_delay),
    .req_i(req_i), .in_i(in_i), .ack_i(ack_i), .out_i(out_i), .out_i_delay(out_i_delay),
    .flush(flush), .busy(busy)
  );

  always #10 clk50MHz = ~clk50MHz;

  int cyc = 0;
  always @(posedge clk50MHz) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: per-channel filter history
  typedef struct { longint y0, y1, x1, x2; } chst_t;
  chst_t m[2];

  typedef struct { bit ch; int val; int exp_out; int exp_dly; } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // floor(v / 2^s) by integer division
  function automatic longint fl(input longint v, input int s);
    longint d;
    d = longint'(1) << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic longint fit(input longint v);
    longint lim, span, r;
    lim  = longint'(1) << (ACC_W - 1);
    span = 2 * lim;
`ifdef BPF_SCHED_SAT_EN
    r = v;
    if (r > lim - 1) r = lim - 1;
    if (r < -lim)    r = -lim;
`else
    r = v % span;
    if (r < 0)    r += span;
    if (r >= lim) r -= span;
`endif
    return r;
  endfunction

  function automatic longint sl(input longint y);
    return fl(y, ACC_W - 14);
  endfunction

  task automatic model_step(input int ch, input int val);
    longint x, a, b, y;
    x = 9 * longint'(val);
    a = m[ch].y0 + fl(m[ch].y0, 1) + fl(m[ch].y0, 2) + fl(m[ch].y0, 5) + fl(m[ch].y0, 8);
    b = m[ch].y1 - fl(m[ch].y1, 4) - fl(m[ch].y1, 7);
    y = fit(a - b + x - m[ch].x2);
    m[ch].y1 = m[ch].y0;
    m[ch].y0 = y;
    m[ch].x2 = m[ch].x1;
    m[ch].x1 = x;
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) m[c] = '{0, 0, 0, 0};
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_out_v"},       out_v,       sl(m[0].y0));
    chk({tag, "_out_v_delay"}, out_v_delay, sl(m[0].y1));
    chk({tag, "_out_i"},       out_i,       sl(m[1].y0));
    chk({tag, "_out_i_delay"}, out_i_delay, sl(m[1].y1));
  endtask

  task automatic drive(input bit ch, input int val, input bit r);
    if (ch) begin in_i = val[12:0]; req_i = r; end
    else    begin in_v = val[12:0]; req_v = r; end
  endtask

  // poll negedges for the channel's ack; g = grant cycle, a = ack cycle
  task automatic wait_ack(input bit ch, input bit hold, output int g, output int a);
    g = -1;
    a = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk50MHz);
      if (busy && g < 0) g = cyc;
      if ((ch ? ack_i : ack_v) === 1'b1) begin
        a = cyc;
        break;
      end
    end
    if (!hold) begin
      if (ch) req_i = 1'b0; else req_v = 1'b0;
    end
  endtask

  task automatic serve(input bit ch, input int val);
    int g, a;
    drive(ch, val, 1'b1);
    wait_ack(ch, 1'b0, g, a);
    chk("ack_seen", a >= 0, 1);
    if (a >= 0) chk("grant_to_ack", a - g, 3);
    chk("other_ack_low", ch ? ack_v : ack_i, 0);
    model_step(ch, val);
    check_outs("serve");
    @(negedge clk50MHz);
    chk("ack_one_cycle", ch ? ack_i : ack_v, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk50MHz);
    flush = 1'b0;
    model_clear();
    check_outs("flush");
  endtask

  task automatic reset_dut();
    @(negedge clk50MHz);
    rst_n = 1'b0; req_v = 1'b0; req_i = 1'b0; flush = 1'b0;
    model_clear();
    repeat (2) @(negedge clk50MHz);
    rst_n = 1'b1;
    repeat (2) @(negedge clk50MHz);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, a, av, ai, rel, ch, val;
    bit overlap, seen;

    rst_n = 1'b0; req_v = 1'b0; req_i = 1'b0; flush = 1'b0; in_v = '0; in_i = '0;
    model_clear();

    // hand-derived results from reset: {channel, input, out, out_delay}
    tbl[0] = '{1'b0,  100,  3, 0};
    tbl[1] = '{1'b0,  100,  9, 3};
    tbl[2] = '{1'b0,    0, 10, 9};
    tbl[3] = '{1'b1,  -50, -2, 0};
    tbl[4] = '{1'b1,  -50, -5, -2};

    repeat (3) @(negedge clk50MHz);
    check_outs("reset");
    chk("reset_ack_v", ack_v, 0);
    chk("reset_ack_i", ack_i, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk50MHz);

    for (int i = 0; i < 5; i++) begin
      serve(tbl[i].ch, tbl[i].val);
      chk("tbl_out", tbl[i].ch ? out_i : out_v, tbl[i].exp_out);
      chk("tbl_dly", tbl[i].ch ? out_i_delay : out_v_delay, tbl[i].exp_dly);
    end

    // req held high through the ack cycle is not served again
    drive(1'b1, 7, 1'b1);
    wait_ack(1'b1, 1'b1, g, a);
    chk("hold_ack_seen", a >= 0, 1);
    model_step(1, 7);
    check_outs("hold");
    @(negedge clk50MHz);
    chk("no_regrant", busy, 0);
    chk("hold_ack_low", ack_i, 0);
    req_i = 1'b0;
    @(negedge clk50MHz);

    // both requests from reset: current first, voltage four cycles later
    reset_dut();
    drive(1'b0, 200, 1'b1);
    drive(1'b1, -300, 1'b1);
    av = -1; ai = -1; overlap = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk50MHz);
      if (ack_v && ack_i) overlap = 1'b1;
      if (ack_i && ai < 0) begin ai = cyc; req_i = 1'b0; end
      if (ack_v && av < 0) begin av = cyc; req_v = 1'b0; end
    end
    req_v = 1'b0; req_i = 1'b0;
    chk("rr_ack_i_seen", ai >= 0, 1);
    chk("rr_ack_v_seen", av >= 0, 1);
    chk("rr_spacing", av - ai, 4);
    chk("rr_no_overlap", overlap, 0);
    model_step(1, -300);
    model_step(0, 200);
    check_outs("rr");

    // flush raised mid-operation: op completes, then flush beats a pending req
    drive(1'b0, 300, 1'b1);
    a = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk50MHz);
      if (busy) flush = 1'b1;
      if (ack_v) begin a = cyc; break; end
    end
    req_v = 1'b0;
    chk("flush_op_ack", a >= 0, 1);
    model_step(0, 300);
    check_outs("pre_flush");
    drive(1'b1, 55, 1'b1);
    @(negedge clk50MHz);
    chk("flush_priority", busy, 0);
    model_clear();
    check_outs("post_flush");
    flush = 1'b0;
    wait_ack(1'b1, 1'b0, g, a);
    chk("after_flush_ack", a >= 0, 1);
    model_step(1, 55);
    check_outs("after_flush");
    @(negedge clk50MHz);

    // reset asserted during CALC: no ack, outputs zero at once, late first grant
    serve(1'b0, 1000);
    drive(1'b0, 500, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk50MHz);
      if (busy) begin seen = 1'b1; break; end
    end
    chk("calc_reached", seen, 1);
    @(negedge clk50MHz);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outs("rst_mid");
    chk("rst_busy", busy, 0);
    chk("rst_ack_v", ack_v, 0);
    repeat (2) begin
      @(negedge clk50MHz);
      chk("rst_no_ack", ack_v, 0);
    end
    rst_n = 1'b1;
    rel = cyc;
    @(negedge clk50MHz);
    chk("no_first_edge_grant", busy, 0);
    wait_ack(1'b0, 1'b0, g, a);
    chk("rst_rel_ack", a >= 0, 1);
    chk("rst_rel_grant_edge", g - rel, 2);
    model_step(0, 500);
    check_outs("rst_rel");
    @(negedge clk50MHz);

    // large negative y0 with constant -4096 input: wrap or clamp
    do_flush();
    force dut.y0_v = -22'sd2000000;
    @(negedge clk50MHz);
    release dut.y0_v;
    m[0].y0 = -2000000;
    check_outs("forced");
    serve(1'b0, -4096);
`ifdef BPF_SCHED_SAT_EN
    chk("sat_clamp", out_v, -8192);
`else
    chk("wrap_value", out_v, 2293);
`endif
    serve(1'b0, -4096);
    serve(1'b0, -4096);

    // impulse response followed by 2000 zero samples
    do_flush();
    serve(1'b0, 4095);
    for (int i = 0; i < 2000; i++) serve(1'b0, 0);
    chk("impulse_decay", (out_v >= -4) && (out_v <= 4), 1);

    // random single-channel traffic with occasional flushes
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      ch  = int'($urandom_range(0, 1));
      val = int'($urandom_range(0, 8191)) - 4096;
      serve(ch[0], val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
